jg3_inverse_encoder: RTL

Sequential inverse of the JG3 3-to-2 judge decoder: given a requested output pair (X,Y), it finds which ABC input codes produce that pair.
- Scans ABC codes 0..7 one per clock, evaluating the JG3 truth table internally.
- Reports the lowest matching code, the number of matches, and a match bitmask.
- Used by test and stimulus logic that needs an ABC value to drive a JG3 instance to a target output.

---
 rtl/jg3_pkg.sv | 26 ++
 rtl/jg3_tt_lut.sv | 13 +
 rtl/jg3_inverse_encoder.sv | 110 +++++++++++
 3 files changed

// File: rtl/jg3_pkg.sv
// Shared definitions for the JG3 inverse encoder: FSM states, XY encodings
// and the fixed JG3 ABC -> XY truth table.
package jg3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

    localparam logic [1:0] XY_00 = 2'b00;
    localparam logic [1:0] XY_01 = 2'b01;
    localparam logic [1:0] XY_10 = 2'b10;
    localparam logic [1:0] XY_11 = 2'b11;

    // No ABC code produces 11; the default arm is unreachable.
    function automatic logic [1:0] jg3_tt(input logic [2:0] abc);
        case (abc)
            3'd0:                   return XY_01;
            3'd1, 3'd2, 3'd3, 3'd4: return XY_00;
            3'd5, 3'd6, 3'd7:       return XY_10;
            default:                return XY_11;
        endcase
    endfunction

endpackage

// File: rtl/jg3_tt_lut.sv
// Combinational JG3 truth-table lookup, usable standalone as a JG3 reference.
module jg3_tt_lut
    import jg3_pkg::*;
(
    input  logic [2:0] abc,
    output logic [1:0] xy
);

    always_comb begin
        xy = jg3_tt(abc);
    end

endmodule

// File: rtl/jg3_inverse_encoder.sv
// Sequential inverse of the JG3 decoder: scans ABC codes 0..7 one per clock
// and reports the lowest matching code, the match count and the match mask.
module jg3_inverse_encoder
    import jg3_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_xy,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_found,
    output logic [2:0] rsp_code,
    output logic [3:0] rsp_count,
    output logic [7:0] rsp_mask,
    output logic       busy
);

    state_t     state;
    state_t     state_nx;
    logic [2:0] idx;
    logic [1:0] target;
    logic [3:0] acc_count;
    logic [7:0] acc_mask;
    logic [2:0] acc_first;
    logic [1:0] tt_xy;
    logic       hit;

    jg3_tt_lut u_lut (
        .abc (idx),
        .xy  (tt_xy)
    );

    assign hit = (tt_xy == target);

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                req_ready = !rst;
                busy      = 1'b0;
                if (req_valid) state_nx = SCAN;
            end
            SCAN: begin
                if (idx == 3'd7 || (EARLY_EXIT && hit)) state_nx = RESP;
            end
            RESP: begin
                if (rsp_valid && rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            target    <= '0;
            acc_count <= '0;
            acc_mask  <= '0;
            acc_first <= '0;
            rsp_valid <= 1'b0;
            rsp_found <= 1'b0;
            rsp_code  <= '0;
            rsp_count <= '0;
            rsp_mask  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        target    <= req_xy;
                        idx       <= '0;
                        acc_count <= '0;
                        acc_mask  <= '0;
                        acc_first <= '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        acc_mask[idx] <= 1'b1;
                        acc_count     <= acc_count + 4'd1;
                        if (acc_count == 4'd0) acc_first <= idx;
                    end
                    if (state_nx == SCAN) idx <= idx + 3'd1;
                end
                RESP: begin
                    // First RESP cycle loads the response registers from the
                    // accumulators; the handshake is only honoured afterwards.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_found <= (acc_count != 4'd0);
                        rsp_code  <= acc_first;
                        rsp_count <= acc_count;
                        rsp_mask  <= acc_mask;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
